systolic_skew_feeder: RTL and testbench

- Source-side companion to systolic_matrix_mult. Accepts one 4x4 GEMM job (A and B operands) over a valid/ready stream and buffers it.
- Pulses the array's clear, then drives a_west0..3 / b_north0..3 with the diagonal skew the array expects, zero-filled outside the active window.
- Waits out the array drain and signals job completion. It replaces hand-written skewed stimulus in front of the array.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_skew_feeder_if.sv | 25 ++
 rtl/skew_lane_sel.sv | 24 ++
 rtl/systolic_skew_feeder.sv | 158 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, stream length and FSM states for the
// systolic array feeder.
package systolic_pkg;
  localparam int DATA_W = 32;
  localparam int N = 4;
  localparam int STREAM_LEN = 2 * N - 1;
  localparam int T_W = $clog2(STREAM_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    STREAM,
    DRAIN
  } state_t;
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: valid/ready operand beat stream
// carrying one column of A and one row of B per beat.
interface systolic_skew_feeder_if #(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int N = systolic_pkg::N
);
  logic in_valid;
  logic in_ready;
  logic [N*DATA_W-1:0] in_a_col;
  logic [N*DATA_W-1:0] in_b_row;

  modport master (
    output in_valid,
    output in_a_col,
    output in_b_row,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a_col,
    input  in_b_row,
    output in_ready
  );
endinterface

// File: rtl/skew_lane_sel.sv
// skew_lane_sel: picks column[t - LANE] for one array lane,
// or zero when the step lies outside that lane's window.
module skew_lane_sel #(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int N = systolic_pkg::N,
  parameter int T_W = systolic_pkg::T_W,
  parameter int LANE = 0
) (
  input  logic [T_W-1:0] t,
  input  logic [N-1:0][DATA_W-1:0] column,
  output logic [DATA_W-1:0] lane_data
);
  localparam int IDX_W = $clog2(N);

  logic [T_W:0] idx;

  always_comb begin
    idx = {1'b0, t} - (T_W+1)'(LANE);
    lane_data = '0;
    if ({1'b0, t} >= (T_W+1)'(LANE) &&
        idx < (T_W+1)'(N))
      lane_data = column[idx[IDX_W-1:0]];
  end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers a 4x4 job, clears the array, streams skewed
// lanes, then drains. SKEW_FEEDER_DONE_WAIT_EN: drain also waits for arr_done.
module systolic_skew_feeder #(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int N = systolic_pkg::N,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  systolic_skew_feeder_if.slave in_if,
  output logic arr_clr,
  input  logic arr_done,
  output logic [DATA_W-1:0] a_west0,
  output logic [DATA_W-1:0] a_west1,
  output logic [DATA_W-1:0] a_west2,
  output logic [DATA_W-1:0] a_west3,
  output logic [DATA_W-1:0] b_north0,
  output logic [DATA_W-1:0] b_north1,
  output logic [DATA_W-1:0] b_north2,
  output logic [DATA_W-1:0] b_north3,
  output logic busy,
  output logic job_done
);
  import systolic_pkg::*;

  if (N != 4) begin : g_n_check
    $error("systolic_skew_feeder supports N == 4 only");
  end

  localparam int K_W = $clog2(N);
  localparam int D_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYCLES - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(STREAM_LEN - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  state_t state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [T_W-1:0] t_q, t_d, t_sel;
  logic [D_W-1:0] d_q, d_d;
  logic ready_c, load_en, lane_en, drain_exit;

  // buffers are indexed [lane][beat]
  logic [N-1:0][N-1:0][DATA_W-1:0] a_buf, b_buf;
  logic [N-1:0][DATA_W-1:0] a_sel, b_sel, a_q, b_q;

`ifdef SKEW_FEEDER_DONE_WAIT_EN
  assign drain_exit = (d_q == D_LAST) && arr_done;
`else
  logic unused_arr_done;
  assign unused_arr_done = arr_done;
  assign drain_exit = (d_q == D_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    t_d      = t_q;
    d_d      = d_q;
    t_sel    = t_q + 1'b1;
    ready_c  = 1'b0;
    load_en  = 1'b0;
    lane_en  = 1'b0;
    arr_clr  = 1'b0;
    busy     = 1'b0;
    job_done = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        ready_c = 1'b1;
        if (in_if.in_valid) begin
          load_en = 1'b1;
          k_d = k_q + 1'b1;
          state_d = (k_q == K_LAST) ? CLEAR : LOAD;
        end
      end
      CLEAR: begin
        arr_clr = 1'b1;
        busy    = 1'b1;
        lane_en = 1'b1;
        t_sel   = '0;
        t_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (t_q == T_LAST) begin
          d_d = '0;
          state_d = DRAIN;
        end else begin
          lane_en = 1'b1;
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_exit) begin
          job_done = 1'b1;
          state_d = IDLE;
        end else begin
          // saturates so the minimum wait holds until arr_done
          d_d = (d_q == D_LAST) ? d_q : d_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_if.in_ready = ready_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      t_q <= '0;
      d_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      t_q <= t_d;
      d_q <= d_d;
      a_q <= lane_en ? a_sel : '0;
      b_q <= lane_en ? b_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !rst) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i][k_q] <= in_if.in_a_col[i*DATA_W +: DATA_W];
        b_buf[i][k_q] <= in_if.in_b_row[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane_sel #(
      .DATA_W(DATA_W), .N(N), .T_W(T_W), .LANE(i)
    ) u_a (
      .t(t_sel), .column(a_buf[i]), .lane_data(a_sel[i])
    );
    skew_lane_sel #(
      .DATA_W(DATA_W), .N(N), .T_W(T_W), .LANE(i)
    ) u_b (
      .t(t_sel), .column(b_buf[i]), .lane_data(b_sel[i])
    );
  end

  assign a_west0  = a_q[0];
  assign a_west1  = a_q[1];
  assign a_west2  = a_q[2];
  assign a_west3  = a_q[3];
  assign b_north0 = b_q[0];
  assign b_north1 = b_q[1];
  assign b_north2 = b_q[2];
  assign b_north3 = b_q[3];
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed checks of load, skewed stream,
// drain timing, reset and back-to-back jobs.
module tb_systolic_skew_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arr_done = 1'b1;
  logic arr_clr, busy, job_done;
  logic [31:0] a_west0, a_west1, a_west2, a_west3;
  logic [31:0] b_north0, b_north1, b_north2, b_north3;

  systolic_skew_feeder_if #(.DATA_W(32), .N(4)) bus();

  systolic_skew_feeder #(.DATA_W(32), .N(4), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_if(bus),
    .arr_clr(arr_clr), .arr_done(arr_done),
    .a_west0(a_west0), .a_west1(a_west1),
    .a_west2(a_west2), .a_west3(a_west3),
    .b_north0(b_north0), .b_north1(b_north1),
    .b_north2(b_north2), .b_north3(b_north3),
    .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] am [4][4];
  logic [31:0] bm [4][4];
  logic [31:0] exp_l [8][7];
  logic [31:0] lane [8];

  assign lane[0] = a_west0;
  assign lane[1] = a_west1;
  assign lane[2] = a_west2;
  assign lane[3] = a_west3;
  assign lane[4] = b_north0;
  assign lane[5] = b_north1;
  assign lane[6] = b_north2;
  assign lane[7] = b_north3;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = 32'(4 * r + c + 1);
        bm[r][c] = 32'(4 * r + c + 1);
      end
    exp_l = '{'{1, 2, 3, 4, 0, 0, 0},
              '{0, 5, 6, 7, 8, 0, 0},
              '{0, 0, 9, 10, 11, 12, 0},
              '{0, 0, 0, 13, 14, 15, 16},
              '{1, 5, 9, 13, 0, 0, 0},
              '{0, 2, 6, 10, 14, 0, 0},
              '{0, 0, 3, 7, 11, 15, 0},
              '{0, 0, 0, 4, 8, 12, 16}};
  endtask

  task automatic set_axi();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = 32'(4 * r + c);
        bm[r][c] = (r == c) ? 32'd1 : 32'd0;
      end
    exp_l = '{'{0, 1, 2, 3, 0, 0, 0},
              '{0, 4, 5, 6, 7, 0, 0},
              '{0, 0, 8, 9, 10, 11, 0},
              '{0, 0, 0, 12, 13, 14, 15},
              '{1, 0, 0, 0, 0, 0, 0},
              '{0, 0, 1, 0, 0, 0, 0},
              '{0, 0, 0, 0, 1, 0, 0},
              '{0, 0, 0, 0, 0, 0, 1}};
  endtask

  task automatic drive_beat(input int k, input logic v);
    bus.in_valid = v;
    for (int i = 0; i < 4; i++) begin
      bus.in_a_col[i*32 +: 32] = v ? am[i][k] : 32'hdead;
      bus.in_b_row[i*32 +: 32] = v ? bm[k][i] : 32'hbeef;
    end
  endtask

  task automatic send(input logic [6:0] pat, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) begin
      drive_beat(k, pat[c]);
      if (pat[c]) check($sformatf("rdy_c%0d", c), bus.in_ready, 1);
      step();
      if (pat[c]) k++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic stream(input string nm);
    check({nm, "_clr"}, arr_clr, 1);
    check({nm, "_rdy_clr"}, bus.in_ready, 0);
    check({nm, "_busy_clr"}, busy, 1);
    step();
    for (int t = 0; t < 7; t++) begin
      for (int l = 0; l < 8; l++)
        check($sformatf("%s_l%0d_t%0d", nm, l, t), lane[l], exp_l[l][t]);
      check($sformatf("%s_clr_t%0d", nm, t), arr_clr, 0);
      check($sformatf("%s_rdy_t%0d", nm, t), bus.in_ready, 0);
      step();
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_done_d%0d", nm, d), job_done, (d == 3) ? 1 : 0);
      check($sformatf("%s_rdy_d%0d", nm, d), bus.in_ready, 0);
      check($sformatf("%s_lane_d%0d", nm, d), a_west3 | b_north3, 0);
      step();
    end
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_idle_rdy"}, bus.in_ready, 1);
    check({nm, "_idle_done"}, job_done, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a_col = '0;
    bus.in_b_row = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_rdy", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clr", arr_clr, 0);
    check("rst_done", job_done, 0);
    check("rst_lanes", a_west0 | a_west3 | b_north0 | b_north3, 0);

    set_m();
    send(7'b0001111, 4);
    stream("m");

    send(7'b1101001, 7);
    stream("stall");

    send(7'b0001111, 4);
    for (int i = 0; i < 4; i++) step();
    check("mid_a0_t3", a_west0, 4);
    check("mid_a3_t3", a_west3, 13);
    rst = 1'b1;
    drive_beat(0, 1'b1);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_lanes", a_west0 | a_west3 | b_north0 | b_north3, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", bus.in_ready, 1);
    check("mid_rst_clr", arr_clr, 0);

    rst = 1'b1;
    drive_beat(0, 1'b1);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    set_axi();
    send(7'b0001111, 4);
    stream("axi");

    begin
      int pulses = 0;
      int first = -1;
      int second = -1;
      logic prev = 1'b0;
      set_m();
      drive_beat(0, 1'b1);
      for (int i = 0; i < 40; i++) begin
        step();
        if (prev) check($sformatf("b2b_rdy_i%0d", i), bus.in_ready, 1);
        prev = job_done;
        if (job_done) begin
          pulses++;
          if (first < 0) first = i;
          else if (second < 0) second = i;
        end
      end
      bus.in_valid = 1'b0;
      check("b2b_pulses", 32'(pulses), 2);
      check("b2b_first", 32'(first), 14);
      check("b2b_gap", 32'(second - first), 16);
      for (int i = 0; i < 30 && busy; i++) step();
      check("b2b_idle", busy, 0);
    end

`ifdef SKEW_FEEDER_DONE_WAIT_EN
    set_m();
    send(7'b0001111, 4);
    arr_done = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int d = 0; d < 10; d++) begin
      check($sformatf("wait_d%0d", d), job_done, 0);
      check($sformatf("wait_busy_d%0d", d), busy, 1);
      step();
    end
    arr_done = 1'b1;
    #1;
    check("wait_done", job_done, 1);
    step();
    check("wait_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
